// File: rtl/zstd_frame_header_parser.sv
// Zstandard frame header parser: takes IN_BYTES-wide beats, consumes one header byte per cycle,
// decodes FHD/WD/DID/FCS, derives Window_Size and hands back payload bytes sharing the last beat.
module zstd_frame_header_parser #(
  parameter int IN_BYTES = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [8*IN_BYTES-1:0]          in_data_i,
  output logic                           busy_o,
  output logic                           finished_o,
  output logic                           error_o,
  output logic [1:0]                     err_code_o,
  output logic [4:0]                     hdr_len_o,
  output logic [7:0]                     frame_header_descriptor_o,
  output logic [7:0]                     window_descriptor_o,
  output logic [31:0]                    dictionary_id_o,
  output logic [63:0]                    frame_content_size_o,
  output logic [63:0]                    window_size_o,
  output logic [8*IN_BYTES-1:0]          extra_data_o,
  output logic [$clog2(IN_BYTES+1)-1:0]  extra_cnt_o
);
  localparam int CW = $clog2(IN_BYTES+1);
  localparam int BW = 8*IN_BYTES;

  typedef enum logic [3:0] {
    S_IDLE, S_MAGIC, S_FHD, S_WD, S_DID, S_FCS, S_CALC, S_DONE, S_ERR
  } state_e;

  function automatic logic [3:0] did_len(input logic [1:0] f);
    case (f)
      2'd0:    did_len = 4'd0;
      2'd1:    did_len = 4'd1;
      2'd2:    did_len = 4'd2;
      default: did_len = 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] fcs_len(input logic [7:0] fhd);
    case (fhd[7:6])
      2'd0:    fcs_len = {3'd0, fhd[5]};
      2'd1:    fcs_len = 4'd2;
      2'd2:    fcs_len = 4'd4;
      default: fcs_len = 4'd8;
    endcase
  endfunction

  // First present field after DID: absent fields are skipped without a bubble.
  function automatic state_e after_did(input logic [7:0] fhd);
    after_did = (fcs_len(fhd) != 4'd0) ? S_FCS : S_CALC;
  endfunction

  function automatic state_e after_wd(input logic [7:0] fhd);
    after_wd = (did_len(fhd[1:0]) != 4'd0) ? S_DID : after_did(fhd);
  endfunction

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    magic_byte = 8'h28;
      2'd1:    magic_byte = 8'hB5;
      2'd2:    magic_byte = 8'h2F;
      default: magic_byte = 8'hFD;
    endcase
  endfunction

  state_e         state_q, state_d;
  logic [BW-1:0]  buf_q, buf_d;
  logic [CW-1:0]  buf_cnt_q, buf_cnt_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [7:0]     fhd_q, fhd_d, wd_q, wd_d;
  logic [31:0]    did_q, did_d;
  logic [63:0]    fcs_q, fcs_d, ws_q, ws_d;
  logic [4:0]     hdr_len_q, hdr_len_d;
  logic [1:0]     err_code_q, err_code_d;
  logic [BW-1:0]  extra_data_q, extra_data_d;
  logic [CW-1:0]  extra_cnt_q, extra_cnt_d;

  logic [7:0]  cur;
  logic [3:0]  fld_len;
  logic        fld_last, parse_st, consume, restart, accept, hdr_end, go_err;
  logic [5:0]  wl;
  logic [63:0] wbase, fcs_acc;

  assign cur      = buf_q[7:0];
  assign parse_st = (state_q == S_MAGIC) || (state_q == S_FHD) || (state_q == S_WD) ||
                    (state_q == S_DID) || (state_q == S_FCS);
  assign consume  = parse_st && (buf_cnt_q != '0);
  assign restart  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign accept   = in_valid_i && in_ready_o;
  assign fld_last = (cnt_q == fld_len - 4'd1);
  assign hdr_end  = consume && (state_d == S_CALC);
  assign go_err   = consume && (state_d == S_ERR);

  always_comb begin
    fld_len = 4'd0;
    case (state_q)
      S_MAGIC: fld_len = 4'd4;
      S_FHD:   fld_len = 4'd1;
      S_WD:    fld_len = 4'd1;
      S_DID:   fld_len = did_len(fhd_q[1:0]);
      S_FCS:   fld_len = fcs_len(fhd_q);
      default: fld_len = 4'd0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start_i) state_d = S_MAGIC;
      S_MAGIC: if (consume) begin
        if (cur != magic_byte(cnt_q[1:0])) state_d = S_ERR;
        else if (fld_last)                 state_d = S_FHD;
      end
      S_FHD: if (consume) begin
        if (cur[3])      state_d = S_ERR;
        else if (!cur[5]) state_d = S_WD;
        else              state_d = after_wd(cur);
      end
      S_WD:   if (consume)             state_d = after_wd(fhd_q);
      S_DID:  if (consume && fld_last) state_d = after_did(fhd_q);
      S_FCS:  if (consume && fld_last) state_d = S_CALC;
      S_CALC: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o     = parse_st || (state_q == S_CALC);
    finished_o = (state_q == S_DONE);
    error_o    = (state_q == S_ERR);
    in_ready_o = parse_st && (buf_cnt_q == '0);
  end

  assign wl      = 6'd10 + {1'b0, wd_q[7:3]};
  assign wbase   = 64'd1 << wl;
  assign fcs_acc = fcs_q | (64'(cur) << {cnt_q, 3'b000});

  always_comb begin
    buf_d        = buf_q;
    buf_cnt_d    = buf_cnt_q;
    cnt_d        = cnt_q;
    fhd_d        = fhd_q;
    wd_d         = wd_q;
    did_d        = did_q;
    fcs_d        = fcs_q;
    ws_d         = ws_q;
    hdr_len_d    = hdr_len_q;
    err_code_d   = err_code_q;
    extra_data_d = extra_data_q;
    extra_cnt_d  = extra_cnt_q;
    if (restart) begin
      buf_d        = '0;
      buf_cnt_d    = '0;
      cnt_d        = '0;
      fhd_d        = '0;
      wd_d         = '0;
      did_d        = '0;
      fcs_d        = '0;
      ws_d         = '0;
      hdr_len_d    = '0;
      err_code_d   = '0;
      extra_data_d = '0;
      extra_cnt_d  = '0;
    end else begin
      if (accept) begin
        buf_d     = in_data_i;
        buf_cnt_d = CW'(IN_BYTES);
      end
      if (consume) begin
        buf_d     = buf_q >> 8;
        buf_cnt_d = buf_cnt_q - CW'(1);
        cnt_d     = fld_last ? 4'd0 : cnt_q + 4'd1;
        if (go_err) begin
          buf_d      = '0;
          buf_cnt_d  = '0;
          err_code_d = (state_q == S_MAGIC) ? 2'd1 : 2'd2;
        end else begin
          hdr_len_d = hdr_len_q + 5'd1;
          case (state_q)
            S_FHD: fhd_d = cur;
            S_WD:  wd_d  = cur;
            S_DID: did_d = did_q | (32'(cur) << {cnt_q, 3'b000});
            S_FCS: fcs_d = (fld_last && fhd_q[7:6] == 2'd1) ? fcs_acc + 64'd256 : fcs_acc;
            default: ;
          endcase
        end
        // Whatever follows the last header byte in this beat is block payload.
        if (hdr_end) begin
          extra_data_d = buf_q >> 8;
          extra_cnt_d  = buf_cnt_q - CW'(1);
          buf_d        = '0;
          buf_cnt_d    = '0;
        end
      end
      if (state_q == S_CALC)
        ws_d = fhd_q[5] ? fcs_q : wbase + (wbase >> 3) * {61'd0, wd_q[2:0]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q        <= '0;
      buf_cnt_q    <= '0;
      cnt_q        <= '0;
      fhd_q        <= '0;
      wd_q         <= '0;
      did_q        <= '0;
      fcs_q        <= '0;
      ws_q         <= '0;
      hdr_len_q    <= '0;
      err_code_q   <= '0;
      extra_data_q <= '0;
      extra_cnt_q  <= '0;
    end else begin
      buf_q        <= buf_d;
      buf_cnt_q    <= buf_cnt_d;
      cnt_q        <= cnt_d;
      fhd_q        <= fhd_d;
      wd_q         <= wd_d;
      did_q        <= did_d;
      fcs_q        <= fcs_d;
      ws_q         <= ws_d;
      hdr_len_q    <= hdr_len_d;
      err_code_q   <= err_code_d;
      extra_data_q <= extra_data_d;
      extra_cnt_q  <= extra_cnt_d;
    end
  end

  assign err_code_o                = err_code_q;
  assign hdr_len_o                 = hdr_len_q;
  assign frame_header_descriptor_o = fhd_q;
  assign window_descriptor_o       = wd_q;
  assign dictionary_id_o           = did_q;
  assign frame_content_size_o      = fcs_q;
  assign window_size_o             = ws_q;
  assign extra_data_o              = extra_data_q;
  assign extra_cnt_o               = extra_cnt_q;
endmodule

// File: tb/tb_zstd_frame_header_parser.sv
// Directed bench: a 2-byte-beat parser for most scenarios plus a 4-byte-beat one for payload carry-over.
module tb_zstd_frame_header_parser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        start, in_valid, in_ready, busy, fin, err;
  logic [15:0] in_data;
  logic [1:0]  err_code;
  logic [4:0]  hdr_len;
  logic [7:0]  fhd, wd;
  logic [31:0] did;
  logic [63:0] fcs, ws;
  logic [15:0] xdata;
  logic [1:0]  xcnt;

  logic        start4, in_valid4, in_ready4, busy4, fin4, err4;
  logic [31:0] in_data4;
  logic [1:0]  err_code4;
  logic [4:0]  hdr_len4;
  logic [7:0]  fhd4, wd4;
  logic [31:0] did4;
  logic [63:0] fcs4, ws4;
  logic [31:0] xdata4;
  logic [2:0]  xcnt4;

  zstd_frame_header_parser #(.IN_BYTES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .busy_o(busy), .finished_o(fin), .error_o(err), .err_code_o(err_code),
    .hdr_len_o(hdr_len), .frame_header_descriptor_o(fhd), .window_descriptor_o(wd),
    .dictionary_id_o(did), .frame_content_size_o(fcs), .window_size_o(ws),
    .extra_data_o(xdata), .extra_cnt_o(xcnt));

  zstd_frame_header_parser #(.IN_BYTES(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
    .in_data_i(in_data4), .busy_o(busy4), .finished_o(fin4), .error_o(err4), .err_code_o(err_code4),
    .hdr_len_o(hdr_len4), .frame_header_descriptor_o(fhd4), .window_descriptor_o(wd4),
    .dictionary_id_o(did4), .frame_content_size_o(fcs4), .window_size_o(ws4),
    .extra_data_o(xdata4), .extra_cnt_o(xcnt4));

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL beat_accept_timeout data=%h waited=%0d cycles limit=100", d, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(fin || err) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL end_timeout waited=%0d cycles, expected finished or error", n);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, fin, err, in_ready, busy4, fin4, err4, in_ready4} !== 8'h00) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000000", {busy, fin, err, in_ready, busy4, fin4, err4, in_ready4});
    end
    checks++;
    if ({hdr_len, fhd, wd, did, fcs, ws, xdata, xcnt, err_code} !== '0) begin
      failures++;
      $display("FAIL reset_fields hdr_len=%h fhd=%h fcs=%h ws=%h exp all 0", hdr_len, fhd, fcs, ws);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, fin, err, in_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=0000", {busy, fin, err, in_ready});
    end
  endtask

  task automatic test_single_segment();
    pulse_start();
    checks++;
    if ({busy, in_ready} !== 2'b11) begin
      failures++;
      $display("FAIL start_busy got=%b exp=11", {busy, in_ready});
    end
    send_beat(16'hB528); send_beat(16'hFD2F); send_beat(16'h2A20);
    wait_end();
    checks++;
    if ({fin, err, busy} !== 3'b100 || fhd !== 8'h20 || fcs !== 64'h2A || ws !== 64'h2A) begin
      failures++;
      $display("FAIL t1_fields fin/err/busy=%b fhd=%h fcs=%h ws=%h exp 100 20 2a 2a", {fin, err, busy}, fhd, fcs, ws);
    end
    checks++;
    if (hdr_len !== 5'd6 || xcnt !== 2'd0 || wd !== 8'h00 || did !== 32'h0) begin
      failures++;
      $display("FAIL t1_len hdr_len=%0d xcnt=%0d wd=%h did=%h exp 6 0 0 0", hdr_len, xcnt, wd, did);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    checks++;
    if (fin !== 1'b0 || hdr_len !== 5'd0 || fhd !== 8'h00 || ws !== 64'h0) begin
      failures++;
      $display("FAIL restart_clear fin=%b hdr_len=%0d fhd=%h ws=%h exp 0 0 0 0", fin, hdr_len, fhd, ws);
    end
    send_beat(16'hB528); send_beat(16'hFD2F); send_beat(16'h5841);
    send_beat(16'h0007); send_beat(16'h5501);
    wait_end();
    checks++;
    if (fin !== 1'b1 || did !== 32'h07 || fcs !== 64'h200 || wd !== 8'h58 || ws !== 64'h200000) begin
      failures++;
      $display("FAIL t2_fields fin=%b did=%h fcs=%h wd=%h ws=%h exp 1 7 200 58 200000", fin, did, fcs, wd, ws);
    end
    checks++;
    if (hdr_len !== 5'd9 || xcnt !== 2'd1 || xdata !== 16'h0055) begin
      failures++;
      $display("FAIL t2_extra hdr_len=%0d xcnt=%0d xdata=%h exp 9 1 0055", hdr_len, xcnt, xdata);
    end
    in_valid = 1'b1;
    in_data  = 16'h1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || xcnt !== 2'd1 || fin !== 1'b1) begin
      failures++;
      $display("FAIL done_blocks_input in_ready=%b xcnt=%0d fin=%b exp 0 1 1", in_ready, xcnt, fin);
    end
  endtask

  task automatic test_window_mantissa();
    pulse_start();
    send_beat(16'hB528); send_beat(16'hFD2F); send_beat(16'h0B00);
    wait_end();
    checks++;
    if (fin !== 1'b1 || ws !== 64'hB00 || fcs !== 64'h0 || hdr_len !== 5'd6 || xcnt !== 2'd0) begin
      failures++;
      $display("FAIL window_mantissa fin=%b ws=%h fcs=%h hdr_len=%0d xcnt=%0d exp 1 b00 0 6 0", fin, ws, fcs, hdr_len, xcnt);
    end
  endtask

  task automatic test_max_fields();
    pulse_start();
    send_beat(16'hB528); send_beat(16'hFD2F); send_beat(16'h11E3); send_beat(16'h3322);
    send_beat(16'h0144); send_beat(16'h0302); send_beat(16'h0504); send_beat(16'h0706);
    send_beat(16'hCC08);
    wait_end();
    checks++;
    if (fin !== 1'b1 || did !== 32'h44332211 || fcs !== 64'h0807060504030201 || ws !== 64'h0807060504030201) begin
      failures++;
      $display("FAIL max_fields fin=%b did=%h fcs=%h ws=%h exp 1 44332211 0807060504030201 same", fin, did, fcs, ws);
    end
    checks++;
    if (hdr_len !== 5'd17 || xcnt !== 2'd1 || xdata !== 16'h00CC) begin
      failures++;
      $display("FAIL max_len hdr_len=%0d xcnt=%0d xdata=%h exp 17 1 00cc", hdr_len, xcnt, xdata);
    end
  endtask

  task automatic test_bad_magic();
    pulse_start();
    send_beat(16'hB527);
    wait_end();
    @(posedge clk); #1;
    checks++;
    if ({err, fin, busy, in_ready} !== 4'b1000 || err_code !== 2'd1) begin
      failures++;
      $display("FAIL bad_magic err/fin/busy/rdy=%b code=%0d exp 1000 1", {err, fin, busy, in_ready}, err_code);
    end
  endtask

  task automatic test_reserved_bit();
    pulse_start();
    checks++;
    if (err !== 1'b0 || err_code !== 2'd0) begin
      failures++;
      $display("FAIL restart_clears_error err=%b code=%0d exp 0 0", err, err_code);
    end
    send_beat(16'hB528); send_beat(16'hFD2F); send_beat(16'h0008);
    wait_end();
    checks++;
    if ({err, fin, busy} !== 3'b100 || err_code !== 2'd2 || fhd !== 8'h00) begin
      failures++;
      $display("FAIL reserved_bit err/fin/busy=%b code=%0d fhd=%h exp 100 2 00", {err, fin, busy}, err_code, fhd);
    end
  endtask

  task automatic test_extra_wide();
    int n = 0;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid4 = 1'b1;
      in_data4  = (b == 0) ? 32'hFD2FB528 : 32'hBBAA2A20;
      n = 0;
      while (!in_ready4 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      @(posedge clk); #1;
      in_valid4 = 1'b0;
    end
    n = 0;
    while (!(fin4 || err4) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (fin4 !== 1'b1 || xcnt4 !== 3'd2 || xdata4[15:0] !== 16'hBBAA || fcs4 !== 64'h2A || hdr_len4 !== 5'd6) begin
      failures++;
      $display("FAIL wide_extra fin=%b xcnt=%0d xdata=%h fcs=%h hdr_len=%0d exp 1 2 bbaa 2a 6", fin4, xcnt4, xdata4[15:0], fcs4, hdr_len4);
    end
  endtask

  task automatic test_reset_mid_parse();
    pulse_start();
    send_beat(16'hB528); send_beat(16'hFD2F); send_beat(16'h1260);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || fhd !== 8'h60 || fin !== 1'b0) begin
      failures++;
      $display("FAIL mid_fcs busy=%b fhd=%h fin=%b exp 1 60 0", busy, fhd, fin);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, fin, err, in_ready} !== 4'b0000 || hdr_len !== 5'd0 || fhd !== 8'h00 || fcs !== 64'h0) begin
      failures++;
      $display("FAIL mid_reset flags=%b hdr_len=%0d fhd=%h fcs=%h exp 0000 0 0 0", {busy, fin, err, in_ready}, hdr_len, fhd, fcs);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    send_beat(16'hB528); send_beat(16'hFD2F);
    repeat (5) @(posedge clk);
    #0;
    checks++;
    if (fin !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL stall_waits fin=%b busy=%b exp 0 1", fin, busy);
    end
    send_beat(16'h2A20);
    wait_end();
    checks++;
    if (fin !== 1'b1 || fhd !== 8'h20 || fcs !== 64'h2A || ws !== 64'h2A || hdr_len !== 5'd6) begin
      failures++;
      $display("FAIL after_reset fin=%b fhd=%h fcs=%h ws=%h hdr_len=%0d exp 1 20 2a 2a 6", fin, fhd, fcs, ws, hdr_len);
    end
  endtask

  initial begin
    start = 1'b0; in_valid = 1'b0; in_data = '0;
    start4 = 1'b0; in_valid4 = 1'b0; in_data4 = '0;
    test_reset();
    test_single_segment();
    test_back_to_back();
    test_window_mantissa();
    test_max_fields();
    test_bad_magic();
    test_reserved_bit();
    test_extra_wide();
    test_reset_mid_parse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
